// File: rtl/p_wqe_mq_buf.sv
`default_nettype none
// ============================================================================
// Module  : p_wqe_mq_buf (with helper mem_1rw1rw)
// Brief   : Multi-channel pending-WQE FIFO buffer sharing one dual-port RAM.
//           Optional macro P_WQE_MQ_BUF_HWM_EN adds per-channel high-water marks.
// Rev     : 1.0
// ============================================================================

module mem_1rw1rw #(
    parameter int    WIDTH             = 8,
    parameter int    DEPTH_LOG         = 4,
    parameter string RAM_STYLE         = "block",
    parameter string DOUT_REG          = "false",
    parameter string READ_DURING_WRITE = "old"
) (
    input  wire logic                 clk,
    input  wire logic                 i_a_en,
    input  wire logic                 i_a_we,
    input  wire logic [DEPTH_LOG-1:0] i_a_addr,
    input  wire logic [WIDTH-1:0]     i_a_din,
    output logic      [WIDTH-1:0]     o_a_dout,
    input  wire logic                 i_b_en,
    input  wire logic                 i_b_we,
    input  wire logic [DEPTH_LOG-1:0] i_b_addr,
    input  wire logic [WIDTH-1:0]     i_b_din,
    output logic      [WIDTH-1:0]     o_b_dout
);
    localparam bit c_RDW_NEW = (READ_DURING_WRITE == "new");

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [1<<DEPTH_LOG];
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;

    always_ff @(posedge clk) begin
        if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_din;
        if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_din;
    end

    // "new" forwards same-cycle write data; "old" returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            r_a_q <= (c_RDW_NEW && i_a_we) ? i_a_din : r_mem[i_a_addr];
        end
        if (i_b_en) begin
            if (c_RDW_NEW && i_b_we)
                r_b_q <= i_b_din;
            else if (c_RDW_NEW && i_a_en && i_a_we && (i_a_addr == i_b_addr))
                r_b_q <= i_a_din;
            else
                r_b_q <= r_mem[i_b_addr];
        end
    end

    generate
        if (DOUT_REG == "true") begin : g_dout_reg
            logic [WIDTH-1:0] r_a_q2;
            logic [WIDTH-1:0] r_b_q2;
            always_ff @(posedge clk) begin
                r_a_q2 <= r_a_q;
                r_b_q2 <= r_b_q;
            end
            assign o_a_dout = r_a_q2;
            assign o_b_dout = r_b_q2;
        end else begin : g_dout_direct
            assign o_a_dout = r_a_q;
            assign o_b_dout = r_b_q;
        end
    endgenerate
endmodule

module p_wqe_mq_buf #(
    parameter int    CHANNEL_NUM    = 4,
    parameter int    CHN_DEPTH_LOG  = 4,
    parameter int    WIDTH_DATA     = 128,
    parameter string RAM_STYLE_MODE = "block",
    parameter string DOUT_REG       = "false",
    localparam int   CHN_W          = $clog2(CHANNEL_NUM),
    localparam int   CNT_W          = CHN_DEPTH_LOG + 1
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         wr_vld,
    input  wire logic [CHN_W-1:0]             wr_chn,
    input  wire logic [WIDTH_DATA-1:0]        wr_data,
    output logic                              wr_rdy,
    input  wire logic                         rd_vld,
    input  wire logic [CHN_W-1:0]             rd_chn,
    output logic                              rd_rdy,
    output logic                              rd_data_vld,
    output logic [WIDTH_DATA-1:0]             rd_data,
    output logic [CHN_W-1:0]                  rd_data_chn,
    input  wire logic [CHANNEL_NUM-1:0]       chn_flush,
    output logic [CHANNEL_NUM-1:0]            chn_empty,
    output logic [CHANNEL_NUM-1:0]            chn_full,
`ifdef P_WQE_MQ_BUF_HWM_EN
    input  wire logic                         hwm_clr,
    output logic [CHANNEL_NUM*CNT_W-1:0]      chn_hwm,
`endif
    output logic [CHANNEL_NUM*CNT_W-1:0]      chn_cnt
);
    localparam int           c_RD_LAT = (DOUT_REG == "true") ? 2 : 1;
    localparam int           c_AW     = CHN_W + CHN_DEPTH_LOG;
    localparam [CNT_W-1:0]   c_DEPTH  = CNT_W'(1 << CHN_DEPTH_LOG);

    logic [CHN_DEPTH_LOG-1:0] r_wr_ptr [CHANNEL_NUM];
    logic [CHN_DEPTH_LOG-1:0] r_rd_ptr [CHANNEL_NUM];
    logic [CNT_W-1:0]         r_cnt    [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0]   r_empty;
    logic [CHANNEL_NUM-1:0]   r_full;
    logic [c_RD_LAT-1:0]      r_pipe_vld;
    logic [CHN_W-1:0]         r_pipe_chn [c_RD_LAT];

    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic [CHANNEL_NUM-1:0]   w_push;
    logic [CHANNEL_NUM-1:0]   w_pop;
    logic [CNT_W-1:0]         w_cnt_next [CHANNEL_NUM];
    logic [c_AW-1:0]          w_wr_addr;
    logic [c_AW-1:0]          w_rd_addr;
    logic [WIDTH_DATA-1:0]    w_b_dout;
    logic [WIDTH_DATA-1:0]    w_a_dout_unused;

    // Ready depends only on registered flags, the flush pulse and reset.
    assign wr_rdy   = ~r_full[wr_chn]  & ~chn_flush[wr_chn] & ~rst;
    assign rd_rdy   = ~r_empty[rd_chn] & ~chn_flush[rd_chn] & ~rst;
    assign w_wr_acc = wr_vld & wr_rdy;
    assign w_rd_acc = rd_vld & rd_rdy;

    assign w_wr_addr = {wr_chn, r_wr_ptr[wr_chn]};
    assign w_rd_addr = {rd_chn, r_rd_ptr[rd_chn]};

    always_comb begin
        w_push         = '0;
        w_pop          = '0;
        w_push[wr_chn] = w_wr_acc;
        w_pop[rd_chn]  = w_rd_acc;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (chn_flush[i])
                w_cnt_next[i] = '0;
            else
                w_cnt_next[i] = r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_empty <= '1;
            r_full  <= '0;
        end else begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (chn_flush[i]) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                end else begin
                    if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                    if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
                r_cnt[i]   <= w_cnt_next[i];
                r_empty[i] <= (w_cnt_next[i] == '0);
                r_full[i]  <= (w_cnt_next[i] == c_DEPTH);
            end
        end
    end

    // Channel tag travels alongside the RAM read so returned data stays labelled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < c_RD_LAT; s++) begin
                r_pipe_vld[s] <= 1'b0;
                r_pipe_chn[s] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            r_pipe_chn[0] <= rd_chn;
            for (int s = 1; s < c_RD_LAT; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_chn[s] <= r_pipe_chn[s-1];
            end
        end
    end

    assign rd_data_vld = r_pipe_vld[c_RD_LAT-1];
    assign rd_data     = rd_data_vld ? w_b_dout : '0;
    assign rd_data_chn = rd_data_vld ? r_pipe_chn[c_RD_LAT-1] : '0;

    mem_1rw1rw #(
        .WIDTH             (WIDTH_DATA),
        .DEPTH_LOG         (c_AW),
        .RAM_STYLE         (RAM_STYLE_MODE),
        .DOUT_REG          (DOUT_REG),
        .READ_DURING_WRITE ("old")
    ) u_mem (
        .clk      (clk),
        .i_a_en   (w_wr_acc),
        .i_a_we   (1'b1),
        .i_a_addr (w_wr_addr),
        .i_a_din  (wr_data),
        .o_a_dout (w_a_dout_unused),
        .i_b_en   (w_rd_acc),
        .i_b_we   (1'b0),
        .i_b_addr (w_rd_addr),
        .i_b_din  ({WIDTH_DATA{1'b0}}),
        .o_b_dout (w_b_dout)
    );

    assign chn_empty = r_empty;
    assign chn_full  = r_full;

    generate
        for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_cnt_flat
            assign chn_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

`ifdef P_WQE_MQ_BUF_HWM_EN
    logic [CNT_W-1:0] r_hwm [CHANNEL_NUM];

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (rst || hwm_clr || chn_flush[i])
                r_hwm[i] <= '0;
            else if (r_cnt[i] > r_hwm[i])
                r_hwm[i] <= r_cnt[i];
        end
    end

    generate
        for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_hwm_flat
            assign chn_hwm[g*CNT_W +: CNT_W] = r_hwm[g];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_p_wqe_mq_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_p_wqe_mq_buf
// Brief   : Self-checking bench with a queue-based reference model.
// Rev     : 1.0
// ============================================================================
module tb_p_wqe_mq_buf;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int CNTW  = 5;
    localparam int W     = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT (DOUT_REG = "false")
    logic            rst = 1'b1;
    logic            wr_vld = 0, rd_vld = 0;
    logic [1:0]      wr_chn = 0, rd_chn = 0;
    logic [W-1:0]    wr_data = '0;
    logic [NCH-1:0]  chn_flush = '0;
    logic            wr_rdy, rd_rdy, rd_data_vld;
    logic [W-1:0]    rd_data;
    logic [1:0]      rd_data_chn;
    logic [NCH-1:0]  chn_empty, chn_full;
    logic [NCH*CNTW-1:0] chn_cnt;
`ifdef P_WQE_MQ_BUF_HWM_EN
    logic            hwm_clr = 1'b0;
    logic [NCH*CNTW-1:0] chn_hwm;
    logic            hwm_clr2 = 1'b0;
    logic [NCH*CNTW-1:0] chn_hwm2;
`endif

    // Second DUT (DOUT_REG = "true")
    logic            rst2 = 1'b1;
    logic            wr_vld2 = 0, rd_vld2 = 0;
    logic [1:0]      wr_chn2 = 0, rd_chn2 = 0;
    logic [W-1:0]    wr_data2 = '0;
    logic [NCH-1:0]  chn_flush2 = '0;
    logic            wr_rdy2, rd_rdy2, rd_data_vld2;
    logic [W-1:0]    rd_data2;
    logic [1:0]      rd_data_chn2;
    logic [NCH-1:0]  chn_empty2, chn_full2;
    logic [NCH*CNTW-1:0] chn_cnt2;

    p_wqe_mq_buf dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_chn(wr_chn), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_vld(rd_vld), .rd_chn(rd_chn), .rd_rdy(rd_rdy),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data), .rd_data_chn(rd_data_chn),
        .chn_flush(chn_flush), .chn_empty(chn_empty), .chn_full(chn_full),
`ifdef P_WQE_MQ_BUF_HWM_EN
        .hwm_clr(hwm_clr), .chn_hwm(chn_hwm),
`endif
        .chn_cnt(chn_cnt)
    );

    p_wqe_mq_buf #(.DOUT_REG("true")) dut2 (
        .clk(clk), .rst(rst2),
        .wr_vld(wr_vld2), .wr_chn(wr_chn2), .wr_data(wr_data2), .wr_rdy(wr_rdy2),
        .rd_vld(rd_vld2), .rd_chn(rd_chn2), .rd_rdy(rd_rdy2),
        .rd_data_vld(rd_data_vld2), .rd_data(rd_data2), .rd_data_chn(rd_data_chn2),
        .chn_flush(chn_flush2), .chn_empty(chn_empty2), .chn_full(chn_full2),
`ifdef P_WQE_MQ_BUF_HWM_EN
        .hwm_clr(hwm_clr2), .chn_hwm(chn_hwm2),
`endif
        .chn_cnt(chn_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one FIFO queue per channel.
    logic [W-1:0] m_q [NCH][$];
    logic         exp_wr_rdy, exp_rd_rdy, exp_vld;
    logic [W-1:0] exp_data;
    logic [1:0]   exp_chn;
    logic         obs_wr_rdy, obs_rd_rdy, obs_vld;
    logic [W-1:0] obs_data;
    logic [1:0]   obs_chn;

    function automatic logic [NCH*CNTW-1:0] model_cnt();
        logic [NCH*CNTW-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i*CNTW +: CNTW] = CNTW'(m_q[i].size());
        return v;
    endfunction

    function automatic logic [NCH-1:0] model_empty();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (m_q[i].size() == 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] model_full();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (m_q[i].size() == DEPTH);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one cycle, advances the model, and captures DUT observations.
    task automatic drive_cycle(input logic wv, input logic [1:0] wc, input logic [W-1:0] wd,
                               input logic rv, input logic [1:0] rc, input logic [NCH-1:0] fl);
        wr_vld = wv; wr_chn = wc; wr_data = wd;
        rd_vld = rv; rd_chn = rc; chn_flush = fl;
        #1;
        obs_wr_rdy = wr_rdy;
        obs_rd_rdy = rd_rdy;
        exp_wr_rdy = (m_q[wc].size() < DEPTH) && !fl[wc];
        exp_rd_rdy = (m_q[rc].size() != 0) && !fl[rc];
        @(posedge clk);
        exp_vld = 1'b0; exp_data = '0; exp_chn = '0;
        if (rv && exp_rd_rdy) begin
            exp_data = m_q[rc].pop_front();
            exp_vld  = 1'b1;
            exp_chn  = rc;
        end
        if (wv && exp_wr_rdy) m_q[wc].push_back(wd);
        for (int i = 0; i < NCH; i++) if (fl[i]) m_q[i].delete();
        #1;
        obs_vld  = rd_data_vld;
        obs_data = rd_data;
        obs_chn  = rd_data_chn;
        wr_vld = 0; rd_vld = 0; chn_flush = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        wr_vld = 1'b1; wr_chn = 2'd0; rd_vld = 1'b1; rd_chn = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wr_rdy, rd_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rdy got=%b want=00", {wr_rdy, rd_rdy});
        end
        n_checks++;
        if ({chn_empty, chn_full, chn_cnt} !== {4'hF, 4'h0, 20'h0}) begin
            n_fail++; $display("FAIL reset_flags empty=%h full=%h cnt=%h want F/0/0", chn_empty, chn_full, chn_cnt);
        end
        n_checks++;
        if ({rd_data_vld, rd_data, rd_data_chn} !== '0) begin
            n_fail++; $display("FAIL reset_rdout vld=%b data=%h chn=%0d want 0", rd_data_vld, rd_data, rd_data_chn);
        end
        wr_vld = 0; rd_vld = 0;
        rst = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < NCH; i++) m_q[i].delete();
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        for (int k = 0; k < 3; k++) begin
            d = W'(8'hA0 + k);
            drive_cycle(1'b1, 2'd2, d, 1'b0, 2'd0, '0);
            n_checks++;
            if (chn_cnt[2*CNTW +: CNTW] !== CNTW'(k + 1)) begin
                n_fail++; $display("FAIL basic_push_cnt got=%0d want=%0d", chn_cnt[2*CNTW +: CNTW], k + 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
            n_checks++;
            if ({obs_vld, obs_data, obs_chn} !== {1'b1, W'(8'hA0 + k), 2'd2}) begin
                n_fail++; $display("FAIL basic_pop vld=%b data=%h chn=%0d want 1/%h/2", obs_vld, obs_data, obs_chn, 8'hA0 + k);
            end
            n_checks++;
            if (chn_cnt[2*CNTW +: CNTW] !== CNTW'(2 - k)) begin
                n_fail++; $display("FAIL basic_pop_cnt got=%0d want=%0d", chn_cnt[2*CNTW +: CNTW], 2 - k);
            end
        end
        n_checks++;
        if (chn_empty[2] !== 1'b1) begin
            n_fail++; $display("FAIL basic_empty got=%b want=1", chn_empty[2]);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) drive_cycle(1'b1, 2'd0, rnd_data(), 1'b0, 2'd0, '0);
        n_checks++;
        if ({chn_full[0], chn_cnt[0 +: CNTW]} !== {1'b1, CNTW'(16)}) begin
            n_fail++; $display("FAIL full_flag full=%b cnt=%0d want 1/16", chn_full[0], chn_cnt[0 +: CNTW]);
        end
        drive_cycle(1'b0, 2'd1, '0, 1'b0, 2'd0, '0);
        n_checks++;
        if (obs_wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL full_other_rdy got=%b want=1", obs_wr_rdy);
        end
        drive_cycle(1'b1, 2'd0, rnd_data(), 1'b0, 2'd0, '0);
        n_checks++;
        if ({obs_wr_rdy, chn_cnt[0 +: CNTW]} !== {1'b0, CNTW'(16)}) begin
            n_fail++; $display("FAIL full_17th rdy=%b cnt=%0d want 0/16", obs_wr_rdy, chn_cnt[0 +: CNTW]);
        end
    endtask

    task automatic test_full_pop();
        drive_cycle(1'b1, 2'd0, rnd_data(), 1'b1, 2'd0, '0);
        n_checks++;
        if ({obs_wr_rdy, obs_rd_rdy, chn_cnt[0 +: CNTW]} !== {1'b0, 1'b1, CNTW'(15)}) begin
            n_fail++; $display("FAIL fullpop wr_rdy=%b rd_rdy=%b cnt=%0d want 0/1/15", obs_wr_rdy, obs_rd_rdy, chn_cnt[0 +: CNTW]);
        end
        n_checks++;
        if ({obs_vld, obs_data, obs_chn} !== {exp_vld, exp_data, exp_chn}) begin
            n_fail++; $display("FAIL fullpop_data got=%b/%h want=%b/%h", obs_vld, obs_data, exp_vld, exp_data);
        end
        drive_cycle(1'b1, 2'd0, rnd_data(), 1'b1, 2'd0, '0);
        n_checks++;
        if ({obs_wr_rdy, obs_rd_rdy, chn_cnt[0 +: CNTW], chn_full[0]} !== {1'b1, 1'b1, CNTW'(15), 1'b0}) begin
            n_fail++; $display("FAIL pushpop15 wr=%b rd=%b cnt=%0d full=%b want 1/1/15/0", obs_wr_rdy, obs_rd_rdy, chn_cnt[0 +: CNTW], chn_full[0]);
        end
        n_checks++;
        if ({obs_vld, obs_data} !== {exp_vld, exp_data}) begin
            n_fail++; $display("FAIL pushpop15_data got=%b/%h want=%b/%h", obs_vld, obs_data, exp_vld, exp_data);
        end
    endtask

`ifdef P_WQE_MQ_BUF_HWM_EN
    task automatic test_hwm();
        n_checks++;
        if (chn_hwm[0 +: CNTW] !== CNTW'(16)) begin
            n_fail++; $display("FAIL hwm_peak got=%0d want=16", chn_hwm[0 +: CNTW]);
        end
        hwm_clr = 1'b1;
        @(posedge clk); #1;
        hwm_clr = 1'b0;
        n_checks++;
        if (chn_hwm !== '0) begin
            n_fail++; $display("FAIL hwm_clr got=%h want=0", chn_hwm);
        end
    endtask
`endif

    task automatic test_wrap();
        int pushed = 0, popped = 0, cyc = 0;
        logic wv, rv;
        while (popped < 40 && cyc < 400) begin
            wv = (pushed < 40) && ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 1) != 0);
            drive_cycle(wv, 2'd3, W'(pushed), rv, 2'd3, '0);
            if (wv && exp_wr_rdy) pushed++;
            n_checks++;
            if ({obs_vld, obs_data, obs_chn} !== {exp_vld, exp_data, exp_chn}) begin
                n_fail++; $display("FAIL wrap_data got=%b/%h/%0d want=%b/%h/%0d", obs_vld, obs_data, obs_chn, exp_vld, exp_data, exp_chn);
            end
            if (exp_vld) popped++;
            cyc++;
        end
        n_checks++;
        if (popped != 40) begin
            n_fail++; $display("FAIL wrap_done popped=%0d want=40", popped);
        end
    endtask

    task automatic test_flush();
        logic [CNTW-1:0] c0;
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 2'd1, rnd_data(), 1'b0, 2'd0, '0);
        c0 = CNTW'(m_q[0].size());
        drive_cycle(1'b0, 2'd0, '0, 1'b1, 2'd1, '0);
        n_checks++;
        if ({obs_vld, obs_data, obs_chn} !== {1'b1, exp_data, 2'd1}) begin
            n_fail++; $display("FAIL flush_inflight got=%b/%h/%0d want=1/%h/1", obs_vld, obs_data, obs_chn, exp_data);
        end
        drive_cycle(1'b1, 2'd1, rnd_data(), 1'b1, 2'd1, 4'b0010);
        n_checks++;
        if ({obs_wr_rdy, obs_rd_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL flush_rdy got=%b want=00", {obs_wr_rdy, obs_rd_rdy});
        end
        n_checks++;
        if ({chn_cnt[1*CNTW +: CNTW], chn_empty[1], chn_cnt[0 +: CNTW]} !== {CNTW'(0), 1'b1, c0}) begin
            n_fail++; $display("FAIL flush_cnt cnt1=%0d empty1=%b cnt0=%0d want 0/1/%0d", chn_cnt[1*CNTW +: CNTW], chn_empty[1], chn_cnt[0 +: CNTW], c0);
        end
        drive_cycle(1'b0, 2'd0, '0, 1'b1, 2'd1, '0);
        n_checks++;
        if ({obs_rd_rdy, obs_vld} !== 2'b00) begin
            n_fail++; $display("FAIL flush_after rd_rdy=%b vld=%b want 0/0", obs_rd_rdy, obs_vld);
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] fl;
        for (int k = 0; k < 400; k++) begin
            fl = ($urandom_range(0, 31) == 0) ? NCH'($urandom_range(1, 15)) : '0;
            drive_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_data(),
                        $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), fl);
            n_checks++;
            if ({obs_wr_rdy, obs_rd_rdy} !== {exp_wr_rdy, exp_rd_rdy}) begin
                n_fail++; $display("FAIL rand_rdy cyc=%0d got=%b want=%b", k, {obs_wr_rdy, obs_rd_rdy}, {exp_wr_rdy, exp_rd_rdy});
            end
            n_checks++;
            if ({obs_vld, obs_data, obs_chn} !== {exp_vld, exp_data, exp_chn}) begin
                n_fail++; $display("FAIL rand_data cyc=%0d got=%b/%h/%0d want=%b/%h/%0d", k, obs_vld, obs_data, obs_chn, exp_vld, exp_data, exp_chn);
            end
            n_checks++;
            if ({chn_cnt, chn_empty, chn_full} !== {model_cnt(), model_empty(), model_full()}) begin
                n_fail++; $display("FAIL rand_state cyc=%0d cnt=%h empty=%h full=%h want %h/%h/%h", k, chn_cnt, chn_empty, chn_full, model_cnt(), model_empty(), model_full());
            end
        end
    endtask

    task automatic test_dout_reg();
        logic [W-1:0] d;
        d = rnd_data();
        @(posedge clk); #1;
        wr_vld2 = 1'b1; wr_chn2 = 2'd0; wr_data2 = d;
        @(posedge clk); #1;
        wr_vld2 = 1'b0; rd_vld2 = 1'b1; rd_chn2 = 2'd0;
        @(posedge clk); #1;
        rd_vld2 = 1'b0;
        n_checks++;
        if (rd_data_vld2 !== 1'b0) begin
            n_fail++; $display("FAIL doutreg_t1 vld=%b want=0", rd_data_vld2);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rd_data_vld2, rd_data2, rd_data_chn2} !== {1'b1, d, 2'd0}) begin
            n_fail++; $display("FAIL doutreg_t2 got=%b/%h want=1/%h", rd_data_vld2, rd_data2, d);
        end
        wr_vld2 = 1'b1; wr_chn2 = 2'd3; wr_data2 = rnd_data();
        @(posedge clk); #1;
        wr_vld2 = 1'b0; rd_vld2 = 1'b1; rd_chn2 = 2'd3;
        @(posedge clk); #1;
        rd_vld2 = 1'b0; rst2 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rd_data_vld2, chn_empty2} !== {1'b0, 4'hF}) begin
            n_fail++; $display("FAIL doutreg_rst vld=%b empty=%h want 0/F", rd_data_vld2, chn_empty2);
        end
        rst2 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({rd_data_vld2, chn_empty2} !== {1'b0, 4'hF}) begin
            n_fail++; $display("FAIL doutreg_rst2 vld=%b empty=%h want 0/F", rd_data_vld2, chn_empty2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_pop();
`ifdef P_WQE_MQ_BUF_HWM_EN
        test_hwm();
`endif
        test_wrap();
        test_flush();
        test_random();
        test_dout_reg();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached limit=500000");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
